// File: rtl/memory_mp_pkg.sv
// memory_mp_pkg
// Shared constants, types and helpers for the multi-channel memory slice.
//   DEF_WIDTH / DEF_DEPTH / DEF_NCH : default parameter values
//   BYTES                           : byte lanes in a default-width word
//   req_t                           : one channel's request bundle (default widths)
//   evenParity()                    : even-parity bit over a zero-extended word
package memory_mp_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_NCH   = 2;
  localparam int BYTES     = DEF_WIDTH / 8;

  typedef struct packed {
    logic                         valid;
    logic                         wr_rd;
    logic [$clog2(DEF_DEPTH)-1:0] addr;
    logic [DEF_WIDTH-1:0]         wdata;
    logic [BYTES-1:0]             be;
  } req_t;

  // Parity bit that makes the total count of ones even.
  function automatic logic evenParity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/memory_mp_if.sv
// memory_mp_if
// Bus bundle between NCH requesters and the shared memory.
//   valid_i / wr_rd_i / addr_i / wdata_i / be_i : per-channel request, packed by channel
//   ready_o  : one-hot (or zero) grant
//   rdata_o  : shared read data; rvalid_o : one-hot owner tag; err_o : error pulse
// Modports: master (requester side), slave (memory side).
interface memory_mp_if
  import memory_mp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NCH        = DEF_NCH
);

  logic [NCH-1:0]             valid_i;
  logic [NCH-1:0]             wr_rd_i;
  logic [NCH*ADDR_WIDTH-1:0]  addr_i;
  logic [NCH*WIDTH-1:0]       wdata_i;
  logic [NCH*(WIDTH/8)-1:0]   be_i;
  logic [NCH-1:0]             ready_o;
  logic [WIDTH-1:0]           rdata_o;
  logic [NCH-1:0]             rvalid_o;
  logic                       err_o;

  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i, be_i,
    input  ready_o, rdata_o, rvalid_o, err_o
  );

  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i, be_i,
    output ready_o, rdata_o, rvalid_o, err_o
  );

endinterface

// File: rtl/memory_rr_arb.sv
// memory_rr_arb
// NCH-wide round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_req        : per-channel request
//   o_grant      : one-hot grant (zero when nothing requests or during reset)
// Search starts at the pointer and wraps; the pointer moves one past the winner.
module memory_rr_arb
  import memory_mp_pkg::*;
#(
  parameter int NCH = DEF_NCH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] i_req,
  output logic [NCH-1:0] o_grant
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]  r_ptr;
  logic [NCH-1:0] w_grant;
  logic [PW-1:0]  w_idx;
  logic           w_found;
  int             w_cand;

  // First requester at or above the pointer, wrapping at NCH.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 0; i < NCH; i++) begin
      w_cand = int'(r_ptr) + i;
      if (w_cand >= NCH) w_cand = w_cand - NCH;
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        w_grant[w_cand] = 1'b1;
        w_idx           = PW'(w_cand);
      end
    end
  end

  // Nothing is granted while reset is held, so no transfer can slip through.
  assign o_grant = rst_i ? '0 : w_grant;

  // Pointer advances past the winner, wrapping explicitly for non-power-of-two NCH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_idx == PW'(NCH - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/memory_mp.sv
// memory_mp
// Multi-channel front-door memory: NCH requesters share one DEPTH x WIDTH store
// through round-robin arbitration, byte-enabled writes and a registered, tagged
// read return.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : memory_mp_if slave modport (requests in, grant/read return out)
// Optional feature macro: MEMORY_MP_PARITY_EN adds one even-parity bit per word;
// a read parity mismatch raises err_o alongside the returned data.
module memory_mp
  import memory_mp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NCH        = DEF_NCH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  memory_mp_if.slave  bus
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_rdata;
  logic [NCH-1:0]        r_rvalid;
  logic                  r_err;

  logic [NCH-1:0]        w_grant;
  logic                  w_any;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WIDTH-1:0]      w_wdata;
  logic [NBYTES-1:0]     w_be;
  logic                  w_inRange;
  logic [WIDTH-1:0]      w_old;
  logic [WIDTH-1:0]      w_merged;
  logic                  w_rdErr;

  memory_rr_arb #(.NCH(NCH)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_req   (bus.valid_i),
    .o_grant (w_grant)
  );

  assign w_any = |w_grant;

  // Route the granted channel's request onto a single internal request.
  always_comb begin
    w_wr    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_be    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_grant[k]) begin
        w_wr    = bus.wr_rd_i[k];
        w_addr  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = bus.wdata_i[k*WIDTH +: WIDTH];
        w_be    = bus.be_i[k*NBYTES +: NBYTES];
      end
    end
  end

  // Out-of-range addresses never touch the array; they read as zero.
  assign w_inRange = int'(w_addr) < DEPTH;
  assign w_old     = w_inRange ? r_mem[w_addr] : '0;

  // Bytes without an enable keep their stored value.
  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < NBYTES; b++) begin
      if (w_be[b]) w_merged[b*8 +: 8] = w_wdata[b*8 +: 8];
    end
  end

`ifdef MEMORY_MP_PARITY_EN
  logic r_par [DEPTH];

  assign w_rdErr = !w_inRange || (evenParity(64'(w_old)) != r_par[w_addr]);

  // Parity is taken over the merged word, so it always matches what is stored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else if (w_any && w_wr && w_inRange) begin
      r_par[w_addr] <= evenParity(64'(w_merged));
    end
  end
`else
  assign w_rdErr = !w_inRange;
`endif

  // Store update plus the one-cycle read return and error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= '0;
      r_err    <= 1'b0;
      if (w_any) begin
        if (w_wr) begin
          if (w_inRange) r_mem[w_addr] <= w_merged;
          r_err <= !w_inRange;
        end else begin
          r_rdata  <= w_old;
          r_rvalid <= w_grant;
          r_err    <= w_rdErr;
        end
      end
    end
  end

  assign bus.ready_o  = w_grant;
  assign bus.rdata_o  = r_rdata;
  assign bus.rvalid_o = r_rvalid;
  assign bus.err_o    = r_err;

endmodule

// File: tb/tb_memory_mp.sv
// tb_memory_mp
// Directed bench for memory_mp (DEPTH=48 so out-of-range addresses exist).
// Each grant pushes the expected response into a scoreboard; a monitor on the
// falling edge pops one entry per grant and compares rvalid/rdata/err, and
// expects a quiet bus with held rdata when nothing was granted.
module tb_memory_mp;

  localparam int WIDTH = 16;
  localparam int DEPTH = 48;
  localparam int AW    = 6;
  localparam int NCH   = 2;

  typedef struct {
    logic [1:0]  rv;
    logic [15:0] data;
    logic        err;
    bit          isRead;
  } exp_t;

  logic clk;
  logic rst;
  logic rstQ = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mdl [DEPTH];
  logic [15:0] lastRdata = '0;
  exp_t sb [$];

  memory_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NCH(NCH)) bus ();

  memory_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NCH(NCH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rstQ <= rst;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  task automatic setChannel(input int ch, input bit wr, input int addr,
                            input logic [15:0] d, input logic [1:0] be);
    bus.valid_i[ch]            = 1'b1;
    bus.wr_rd_i[ch]            = wr;
    bus.addr_i[ch*AW +: AW]    = AW'(addr);
    bus.wdata_i[ch*16 +: 16]   = d;
    bus.be_i[ch*2 +: 2]        = be;
  endtask

  // Drive a lone request on one channel (call right after a falling edge).
  task automatic applyStimulus(input int ch, input bit wr, input int addr,
                               input logic [15:0] d, input logic [1:0] be);
    bus.valid_i = '0;
    setChannel(ch, wr, addr, d, be);
  endtask

  // Check the grant, then record the expected response from the bench model.
  task automatic settleAndGrant(input string tag, input logic [1:0] expReady);
    int ch;
    int a;
    logic [15:0] wd;
    logic [1:0]  be;
    exp_t e;
    #1;
    checkOutput(tag, {30'd0, bus.ready_o}, {30'd0, expReady});
    if (expReady != 2'b00) begin
      ch = expReady[1] ? 1 : 0;
      a  = int'(bus.addr_i[ch*AW +: AW]);
      wd = bus.wdata_i[ch*16 +: 16];
      be = bus.be_i[ch*2 +: 2];
      e.err = (a >= DEPTH);
      if (bus.wr_rd_i[ch]) begin
        e.rv = 2'b00; e.data = '0; e.isRead = 1'b0;
        if (a < DEPTH) begin
          if (be[0]) mdl[a][7:0]  = wd[7:0];
          if (be[1]) mdl[a][15:8] = wd[15:8];
        end
      end else begin
        e.rv = expReady; e.isRead = 1'b1;
        e.data = (a < DEPTH) ? mdl[a] : 16'h0000;
      end
      sb.push_back(e);
    end
  endtask

  // One scoreboard entry per grant; idle cycles must be quiet with rdata held.
  always @(negedge clk) begin
    exp_t e;
    if (rstQ) begin
      checkOutput("rst_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
      checkOutput("rst_err", {31'd0, bus.err_o}, 32'd0);
      checkOutput("rst_rdata", {16'd0, bus.rdata_o}, 32'd0);
      lastRdata = '0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("rvalid", {30'd0, bus.rvalid_o}, {30'd0, e.rv});
      checkOutput("err", {31'd0, bus.err_o}, {31'd0, e.err});
      if (e.isRead) begin
        checkOutput("rdata", {16'd0, bus.rdata_o}, {16'd0, e.data});
        lastRdata = e.data;
      end else begin
        checkOutput("rdata_hold", {16'd0, bus.rdata_o}, {16'd0, lastRdata});
      end
    end else begin
      checkOutput("idle_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
      checkOutput("idle_err", {31'd0, bus.err_o}, 32'd0);
      checkOutput("idle_rdata", {16'd0, bus.rdata_o}, {16'd0, lastRdata});
    end
  end

  initial begin
    rst         = 1'b1;
    bus.valid_i = '0;
    bus.wr_rd_i = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.be_i    = '0;
    clearModel();

    // Both channels request through reset: no grant while reset is held.
    @(negedge clk);
    setChannel(0, 1'b0, 0, 16'h0, 2'b00);
    setChannel(1, 1'b0, 1, 16'h0, 2'b00);
    settleAndGrant("ready_in_reset", 2'b00);
    @(negedge clk);
    settleAndGrant("ready_in_reset", 2'b00);

    // Continuous load from reset alternates starting with channel 0.
    @(negedge clk);
    rst = 1'b0;
    settleAndGrant("arb_c0", 2'b01);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      settleAndGrant("arb_alt", (i % 2 == 1) ? 2'b10 : 2'b01);
    end

    // Every in-range word reads zero after reset.
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk); applyStimulus(0, 1'b0, a, 16'h0, 2'b00);
      settleAndGrant("rd_zero_grant", 2'b01);
    end

    // Cross-channel write then read.
    @(negedge clk); applyStimulus(0, 1'b1, 5, 16'hA5C3, 2'b11);
    settleAndGrant("wr5_grant", 2'b01);
    @(negedge clk); applyStimulus(1, 1'b0, 5, 16'h0, 2'b00);
    settleAndGrant("rd5_grant", 2'b10);

    // Partial byte write, then an all-disabled write that must change nothing.
    @(negedge clk); applyStimulus(0, 1'b1, 9, 16'h1234, 2'b11);
    settleAndGrant("wr9_grant", 2'b01);
    @(negedge clk); applyStimulus(0, 1'b1, 9, 16'hFFFF, 2'b01);
    settleAndGrant("wr9_be01_grant", 2'b01);
    @(negedge clk); applyStimulus(1, 1'b0, 9, 16'h0, 2'b00);
    settleAndGrant("rd9_grant", 2'b10);
    @(negedge clk); applyStimulus(1, 1'b1, 9, 16'h0000, 2'b00);
    settleAndGrant("wr9_be00_grant", 2'b10);
    @(negedge clk); applyStimulus(0, 1'b0, 9, 16'h0, 2'b00);
    settleAndGrant("rd9b_grant", 2'b01);

    // Out of range: write dropped, read zero, err on both; last word works.
    @(negedge clk); applyStimulus(0, 1'b1, 50, 16'hBEEF, 2'b11);
    settleAndGrant("wr50_grant", 2'b01);
    @(negedge clk); applyStimulus(0, 1'b0, 50, 16'h0, 2'b00);
    settleAndGrant("rd50_grant", 2'b01);
    @(negedge clk); applyStimulus(1, 1'b1, 47, 16'h5A01, 2'b11);
    settleAndGrant("wr47_grant", 2'b10);
    @(negedge clk); applyStimulus(0, 1'b0, 47, 16'h0, 2'b00);
    settleAndGrant("rd47_grant", 2'b01);

    // Move the pointer to channel 1, then reset while channel 1 requests.
    @(negedge clk); applyStimulus(0, 1'b0, 3, 16'h0, 2'b00);
    settleAndGrant("pre_rst_grant", 2'b01);
    @(negedge clk);
    rst = 1'b1;
    clearModel();
    applyStimulus(1, 1'b0, 7, 16'h0, 2'b00);
    settleAndGrant("rd_in_reset", 2'b00);
    @(negedge clk);
    rst = 1'b0;
    setChannel(0, 1'b0, 5, 16'h0, 2'b00);
    settleAndGrant("post_rst_c0_first", 2'b01);
    @(negedge clk); applyStimulus(1, 1'b0, 47, 16'h0, 2'b00);
    settleAndGrant("post_rst_c1", 2'b10);

    @(negedge clk);
    bus.valid_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_mp.md
# memory_mp

Multi-channel front-door memory: the next generation of the single-port `memory` block. NCH independent requesters share one DEPTH×WIDTH register-array store through per-channel valid/ready handshakes, arbitrated round-robin, with byte-enabled writes and a registered, tagged read return. It sits behind bus adapters or DMA engines that previously each needed a private memory.

## Interface
Parameters:
- WIDTH, 16, data word width in bits; multiple of 8.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NCH, 2, number of requester channels, 1..8.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  NCH  per-channel request valid.
- wr_rd_i  input  NCH  per-channel 1 = write, 0 = read.
- addr_i  input  NCH*ADDR_WIDTH  per-channel address; channel k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  input  NCH*WIDTH  per-channel write data.
- be_i  input  NCH*(WIDTH/8)  per-channel byte enables; ignored on reads.
- ready_o  output  NCH  per-channel grant; one-hot or zero.
- rdata_o  output  WIDTH  read data, shared by all channels.
- rvalid_o  output  NCH  one-hot tag: rdata_o belongs to channel k.
- err_o  output  1  one-cycle pulse: accepted access was out of range (or parity error, see Configuration).

## Operation
- Transfer on channel k occurs in a cycle where valid_i[k] && ready_o[k]; requester holds valid/wr_rd/addr/wdata/be stable until then.
- ready_o is combinational from valid_i and the round-robin pointer; at most one bit set per cycle.
- Arbitration: starting at channel rr_ptr, search upward (wrapping NCH-1→0) for first valid; grant it; rr_ptr ← granted+1 mod NCH at that edge. No valid → no grant, rr_ptr held.
- Write: at grant edge, each byte b with be_i[b] set is updated; others keep value. be all-zero → no change, still a completed transfer.
- Read: rdata_o and rvalid_o[k] registered at grant edge; both valid for exactly the following cycle. rvalid_o zero otherwise; rdata_o holds last value when rvalid_o is zero.
- Address ≥ DEPTH: write discarded; read returns 0 with rvalid; err_o pulses the cycle after grant.
- Read of address just written (any channel, previous cycle) returns new data; no hazard since one access per cycle.
- Reset: all words 0, rr_ptr 0, ready_o 0 during reset cycles, rvalid_o 0, rdata_o 0, err_o 0. Reset asserted while a read is granted: that read's rvalid is suppressed; requester must reissue.

## Timing
- Grant: same cycle as valid when channel is first from rr_ptr; worst-case wait NCH-1 cycles under full load.
- Write latency: 0 (visible to a read granted the next cycle).
- Read latency: 1 cycle from grant edge to rvalid_o/rdata_o.
- Throughput: one access per cycle aggregate; back-to-back grants to the same channel allowed only when no other channel is valid.
- err_o aligned with the rvalid_o cycle of the offending access (for writes: the cycle after grant).

## Configuration
- MEMORY_MP_PARITY_EN defined: each word stores one extra even-parity bit computed over the post-byte-enable written word; on read, mismatch sets err_o in the rvalid cycle (data still returned). Reset clears parity bits to 0 (consistent with zero data).
- Undefined: no parity storage; err_o reports only out-of-range.

## Structure
- Package memory_mp_pkg: default parameter constants, BYTES = WIDTH/8, function for even parity, typedef for per-channel request struct (valid, wr_rd, addr, wdata, be).
- Sub-module memory_rr_arb: NCH-wide round-robin arbiter (req in, one-hot grant out, pointer register, sync reset). Store, byte-enable merge, read register and error logic stay in memory_mp.

## Test plan
- Reset then read addr 0..DEPTH-1 on channel 0 → every rdata_o = 0, rvalid_o = 'b01, err_o = 0.
- Ch0 write addr 5 data 16'hA5C3 be 'b11, then ch1 read addr 5 → ch1 rvalid, rdata_o = 16'hA5C3 one cycle after grant.
- Write addr 9 16'h1234 be 'b11, then 16'hFFFF be 'b01, read → 16'h12FF.
- Both channels valid continuously for 8 cycles from reset → grants alternate ch0,ch1,ch0,… ; no channel waits >1 cycle.
- DEPTH=48: write addr 50, read addr 50 → write discarded, read rdata 0, err_o pulses twice; addr 47 read/write works normally.
- Reset asserted in the cycle a ch1 read is granted → no rvalid_o next cycle, rr_ptr 0, subsequent ch0/ch1 simultaneous request grants ch0 first.
